// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Brief    : 16-line direct-mapped, write-through / no-write-allocate cache
//            controller with a single-outstanding-request backing-memory port.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        cache_hit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int C_LINES = 16;
  localparam int C_TAG_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t               r_state;
  logic [C_LINES-1:0]   r_valid;
  logic [C_TAG_W-1:0]   r_tag  [C_LINES];
  logic [15:0]          r_data [C_LINES];
  logic [15:0]          r_req_addr;
  logic [15:0]          r_req_din;
  logic                 r_req_rd;
  logic                 r_req_wr;

  logic [3:0]           w_idx;
  logic [C_TAG_W-1:0]   w_tag;
  logic                 w_hit;
  logic                 w_req_changed;
  logic [15:0]          w_mem_addr;

  // Lookup uses the live address in IDLE and the captured one while busy.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_idx = addr[4:1];
      w_tag = addr[15:5];
    end else begin
      w_idx = r_req_addr[4:1];
      w_tag = r_req_addr[15:5];
    end
    w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_req_changed = ({addr, data_in, rd, wr} !=
                     {r_req_addr, r_req_din, r_req_rd, r_req_wr});
    w_mem_addr    = {r_req_addr[15:1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_valid    <= '0;
      r_req_addr <= '0;
      r_req_din  <= '0;
      r_req_rd   <= 1'b0;
      r_req_wr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_addr <= addr;
          r_req_din  <= data_in;
          r_req_rd   <= rd;
          r_req_wr   <= wr;
          // rd and wr together is an error but still completes as a store
          if (wr) begin
            r_state <= ST_WRITE;
          end else if (rd && !w_hit) begin
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            r_valid[w_idx] <= 1'b1;
            r_tag[w_idx]   <= w_tag;
            r_data[w_idx]  <= mem_rdata;
            r_state        <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            if (w_hit) begin
              r_data[w_idx] <= r_req_din;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_out  = '0;
    done      = 1'b0;
    stall     = 1'b0;
    cache_hit = 1'b0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          err = (rd && wr) || mem_ready;
          if (wr) begin
            stall = 1'b1;
          end else if (rd) begin
            if (w_hit) begin
              done      = 1'b1;
              cache_hit = 1'b1;
              data_out  = r_data[w_idx];
            end else begin
              stall = 1'b1;
            end
          end
        end
        ST_FILL: begin
          mem_rd   = 1'b1;
          mem_addr = w_mem_addr;
          err      = w_req_changed;
          if (mem_ready) begin
            done     = 1'b1;
            data_out = mem_rdata;
          end else begin
            stall = 1'b1;
          end
        end
        ST_WRITE: begin
          mem_wr    = 1'b1;
          mem_addr  = w_mem_addr;
          mem_wdata = r_req_din;
          err       = w_req_changed;
          if (mem_ready) begin
            done      = 1'b1;
            cache_hit = w_hit;
          end else begin
            stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl
// Brief    : Scoreboard bench for cache_ctrl with a variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, data_in, mem_rdata;
  logic        rd, wr, mem_ready;
  logic [15:0] data_out, mem_addr, mem_wdata;
  logic        done, stall, cache_hit, err, mem_rd, mem_wr;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .done(done), .stall(stall), .cache_hit(cache_hit),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
    logic        hit;
    logic        err;
    int          stalls;
    int          mem_cycles;
    logic [15:0] maddr;
    logic [15:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] bmem [logic [15:0]];
  logic [15:0] mvalid;
  logic [10:0] mtag [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_get(input logic [15:0] a);
    logic [15:0] k;
    k = {a[15:1], 1'b0};
    if (bmem.exists(k)) return bmem[k];
    return k ^ 16'hA5A5;
  endfunction

  task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input int lat, input bit glitch);
    exp_t        e, got_e;
    int          stalls = 0;
    int          memcnt = 0;
    bit          seen_err = 0, got_done = 0, both = 0;
    logic [3:0]  idx;
    logic [10:0] tg;
    idx          = a[4:1];
    tg           = a[15:5];
    e.hit        = mvalid[idx] && (mtag[idx] == tg);
    e.is_rd      = r && !w;
    e.data       = e.is_rd ? mem_get(a) : 16'h0000;
    e.err        = (r && w) || glitch;
    e.stalls     = (e.is_rd && e.hit) ? 0 : lat + 1;
    e.mem_cycles = (e.is_rd && e.hit) ? 0 : lat;
    e.maddr      = {a[15:1], 1'b0};
    e.wdata      = d;
    sb.push_back(e);
    if (e.is_rd) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end else begin
      bmem[e.maddr] = d;
    end

    @(posedge clk); #1;
    addr = a; data_in = d; rd = r; wr = w; mem_ready = 1'b0;
    for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        mem_ready = (memcnt >= lat);
        mem_rdata = mem_ready ? mem_get(mem_addr) : 16'($urandom);
        data_in   = (glitch && cyc == 2) ? (d ^ 16'h0001) : d;
      end
      @(negedge clk);
      if (err) seen_err = 1;
      if (mem_rd && mem_wr) both = 1;
      if (done) begin
        got_done = 1;
        got_e = sb.pop_front();
        chk($sformatf("data_out@%h", a), data_out, got_e.data);
        chk($sformatf("cache_hit@%h", a), cache_hit, got_e.hit);
        chk($sformatf("stalls@%h", a), stalls, got_e.stalls);
        chk($sformatf("mem_cycles@%h", a), memcnt, got_e.mem_cycles);
        chk($sformatf("err@%h", a), seen_err, got_e.err);
      end else begin
        if (stall) stalls++;
        if (mem_rd || mem_wr) begin
          if (memcnt == 0) begin
            chk($sformatf("mem_addr@%h", a), mem_addr, e.maddr);
            chk($sformatf("mem_rd@%h", a), mem_rd, e.is_rd);
            if (!e.is_rd) chk($sformatf("mem_wdata@%h", a), mem_wdata, e.wdata);
          end
          memcnt++;
        end
      end
    end
    if (!got_done) begin
      chk($sformatf("done_timeout@%h", a), got_done, 1);
      void'(sb.pop_front());
    end
    chk("mem_rd_wr_exclusive", both, 0);

    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {done, stall, mem_rd, mem_wr, data_out}, 0);
  endtask

  task automatic model_reset();
    mvalid = '0;
    for (int i = 0; i < 16; i++) mtag[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; addr = 16'h0024; data_in = 16'hFFFF; rd = 1'b1; wr = 1'b1;
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    model_reset();
    bmem[16'h0024] = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {done, stall, cache_hit, err, mem_rd, mem_wr}, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; mem_ready = 1'b0;

    do_req(1, 0, 16'h0024, 16'h0000, 3, 0);  // cold miss
    do_req(1, 0, 16'h0024, 16'h0000, 3, 0);  // hit
    do_req(1, 0, 16'h0064, 16'h0000, 2, 0);  // conflict
    do_req(1, 0, 16'h0024, 16'h0000, 1, 0);  // evicted, misses again
    do_req(0, 1, 16'h0024, 16'h1234, 2, 0);  // write hit
    do_req(1, 0, 16'h0024, 16'h0000, 1, 0);
    do_req(0, 1, 16'h0100, 16'h5555, 1, 0);  // write miss, no allocate
    do_req(1, 0, 16'h0100, 16'h0000, 2, 0);
    do_req(1, 0, 16'h0101, 16'h0000, 2, 0);  // bit 0 ignored
    do_req(1, 1, 16'h0100, 16'h7777, 1, 0);  // rd+wr -> err, store
    do_req(1, 0, 16'h0100, 16'h0000, 1, 0);
    do_req(1, 0, 16'h0066, 16'h0000, 3, 1);  // input changed mid-fill

    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_err", err, 1);
    chk("idle_ready_done", done, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      logic [15:0] pool [5];
      logic        r;
      pool = '{16'h0024, 16'h0064, 16'h0100, 16'h0026, 16'h8024};
      r = 1'($urandom_range(0, 1));
      do_req(r, !r, pool[$urandom_range(0, 4)], 16'($urandom),
             int'($urandom_range(1, 3)), 0);
    end

    // abort a fill with reset
    @(posedge clk); #1;
    addr = 16'h0200; rd = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_fill_active", mem_rd, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_outs", {mem_rd, mem_wr, stall, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0; rd = 1'b0;
    @(negedge clk);
    chk("abort_idle_after", {mem_rd, mem_wr, stall, done}, 0);
    model_reset();
    do_req(1, 0, 16'h0200, 16'h0000, 2, 0);
    do_req(1, 0, 16'h0024, 16'h0000, 1, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Port clk  input  1  system clock; every state element updates on the rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port addr  input  16  byte address from the pipeline; bit 0 is ignored; index = addr[4:1], tag = addr[15:5].
REQ-005 Port data_in  input  16  store data.
REQ-006 Port rd  input  1  load request; must be held until done.
REQ-007 Port wr  input  1  store request; must be held until done.
REQ-008 Port data_out  output  16  load result; valid when done=1 for a read.
REQ-009 Port done  output  1  one-cycle pulse marking request completion.
REQ-010 Port stall  output  1  pipeline must hold its registers while stall=1.
REQ-011 Port cache_hit  output  1  high with done when the request hit.
REQ-012 Port err  output  1  illegal condition flag, ORed into the processor err.
REQ-013 Port mem_addr  output  16  backing-memory address.
REQ-014 Port mem_wdata  output  16  backing-memory write data.
REQ-015 Port mem_rd, mem_wr  output  1 each  backing-memory commands, held until mem_ready.
REQ-016 Port mem_rdata  input  16  backing-memory read data, valid when mem_ready=1.
REQ-017 Port mem_ready  input  1  backing memory has completed the command this cycle; latency is 1..N cycles.

Function
REQ-018 Storage SHALL be 16 direct-mapped lines, each holding valid(1), tag(11) and data(16).
REQ-019 The FSM SHALL have three states: IDLE, FILL and WRITE.
REQ-020 IDLE read hit (valid and tag match): done=1, cache_hit=1, data_out=line data, stall=0, all in the same cycle; no memory access.
REQ-021 IDLE read miss: go to FILL next cycle; stall=1 in the miss cycle and in every FILL cycle.
REQ-022 FILL: mem_rd=1 and mem_addr={addr[15:1],1'b0}; on mem_ready, write line {valid=1, tag, mem_rdata}, drive done=1 and data_out=mem_rdata, set cache_hit=0 and stall=0, and return to IDLE.
REQ-023 IDLE write: go to WRITE next cycle; stall=1.
REQ-024 The cache SHALL be write-through and no-write-allocate: WRITE holds mem_wr=1, mem_addr and mem_wdata=data_in until mem_ready.
REQ-025 On mem_ready in WRITE: if the line is a hit, its data becomes data_in; on a miss the line is unchanged. The same cycle drives done=1, cache_hit=hit and stall=0, and the FSM returns to IDLE.
REQ-026 mem_rd and mem_wr SHALL never be high together, and SHALL both be 0 in IDLE.
REQ-027 rd and wr both high in IDLE: err=1 for that cycle; the request is treated as a write.
REQ-028 mem_ready while in IDLE: err=1 and the input is ignored.
REQ-029 Outside done cycles, data_out SHALL be 0.
REQ-030 A new request may be accepted in the cycle after done; there is no back-to-back completion within the same cycle.
REQ-031 addr, rd, wr and data_in SHALL be sampled while in FILL or WRITE. Any change to them while in those states is a requester violation and sets err=1.

Reset
REQ-032 While rst=1, all lines SHALL be marked invalid and the FSM forced to IDLE; data and tag contents are don't-care.
REQ-033 While rst=1, all outputs SHALL be 0: done, stall, cache_hit, err, mem_rd, mem_wr, data_out, mem_addr and mem_wdata.
REQ-034 Reset asserted during FILL or WRITE SHALL abort the operation: no line is written, and mem_rd/mem_wr drop in the next cycle.
REQ-035 The first request after reset SHALL always miss.

Verification
REQ-036 Cold read miss: rd addr=0x0024, mem_rdata=0xBEEF with 3-cycle latency -> stall for 4 cycles, then done=1, data_out=0xBEEF, cache_hit=0.
REQ-037 Read hit: repeat rd 0x0024 -> same-cycle done=1, cache_hit=1, data_out=0xBEEF, mem_rd never asserted.
REQ-038 Conflict: rd 0x0064 (same index, tag differs) misses and refills; a following rd 0x0024 misses again.
REQ-039 Write hit: wr 0x0024 data 0x1234, mem_ready after 2 cycles -> mem_wr held with mem_wdata=0x1234, done with cache_hit=1; the next rd 0x0024 hits with 0x1234.
REQ-040 Write miss: wr 0x0100 -> memory written, done with cache_hit=0; the next rd 0x0100 misses.
REQ-041 Error and reset: rd=wr=1 -> err=1; rst asserted mid-FILL -> mem_rd=0 next cycle, and the next rd to the same address misses.
